// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Opcodes, sequencer state type and helpers shared by the ALU
//            operand/result sequencer. Optional build macro used by the
//            sequencer: ALU_SEQ_DIV_ZERO_TRAP_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int CNT_W = 8;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_e;

   function automatic logic is_legal_op(input logic [4:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
         default:                                        legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Latencies below 1 would never reach the terminal count, so clamp.
   function automatic logic [CNT_W-1:0] lat_sel(input logic [4:0] op,
                                                input int base_lat,
                                                input int mul_lat,
                                                input int div_lat);
      int v;
      case (op)
         OP_MUL:  v = mul_lat;
         OP_DIV:  v = div_lat;
         default: v = base_lat;
      endcase
      if (v < 1)   v = 1;
      if (v > 255) v = 255;
      return v[CNT_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wait_counter.sv
// ============================================================================
//  Module  : alu_wait_counter
//  Brief   : Loadable down-counter; term_o flags the last wait cycle (count 1).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_wait_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         term_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign term_o = (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module  : alu_op_sequencer
//  Brief   : Issues one ALU operation (operands, opcode, toggle trigger), waits
//            an opcode-dependent latency and captures the 64-bit result.
//            Build option: ALU_SEQ_DIV_ZERO_TRAP_EN traps divide-by-zero.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int BASE_LAT = 1,
   parameter int MUL_LAT  = 2,
   parameter int DIV_LAT  = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [31:0] alu_y,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_control,
   output logic        alu_in,
   input  logic [63:0] alu_z,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo
);

   seq_state_e  state_q, state_d;
   logic [31:0] alu_y_q, alu_y_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [4:0]  alu_ctrl_q, alu_ctrl_d;
   logic        alu_in_q, alu_in_d;
   logic [31:0] z_hi_q, z_hi_d;
   logic [31:0] z_lo_q, z_lo_d;
   logic        illegal_q, illegal_d;

   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_term;
   logic        op_rejected;

`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
   assign op_rejected = !is_legal_op(alu_ctrl_q) ||
                        ((alu_ctrl_q == OP_DIV) && (alu_b_q == 32'd0));
`else
   assign op_rejected = !is_legal_op(alu_ctrl_q);
`endif

   always_comb begin
      state_d    = state_q;
      alu_y_d    = alu_y_q;
      alu_b_d    = alu_b_q;
      alu_ctrl_d = alu_ctrl_q;
      alu_in_d   = alu_in_q;
      z_hi_d     = z_hi_q;
      z_lo_d     = z_lo_q;
      illegal_d  = illegal_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               alu_y_d    = operand_a;
               alu_b_d    = operand_b;
               alu_ctrl_d = opcode;
               illegal_d  = 1'b0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (op_rejected) begin
               illegal_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The ALU re-evaluates on any edge of alu_in, so one toggle = one op.
            alu_in_d = ~alu_in_q;
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_term) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            z_hi_d  = alu_z[63:32];
            z_lo_d  = alu_z[31:0];
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= ST_IDLE;
         alu_y_q    <= 32'd0;
         alu_b_q    <= 32'd0;
         alu_ctrl_q <= 5'd0;
         alu_in_q   <= 1'b0;
         z_hi_q     <= 32'd0;
         z_lo_q     <= 32'd0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_y_q    <= alu_y_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
         alu_in_q   <= alu_in_d;
         z_hi_q     <= z_hi_d;
         z_lo_q     <= z_lo_d;
         illegal_q  <= illegal_d;
      end
   end

   alu_wait_counter #(
      .W (CNT_W)
   ) u_wait_counter (
      .clock      (clock),
      .clear      (clear),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (lat_sel(alu_ctrl_q, BASE_LAT, MUL_LAT, DIV_LAT)),
      .term_o     (cnt_term)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign illegal     = (state_q == ST_DONE) && illegal_q;
   assign alu_y       = alu_y_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_ctrl_q;
   assign alu_in      = alu_in_q;
   assign z_hi        = z_hi_q;
   assign z_lo        = z_lo_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module  : tb_alu_op_sequencer
//  Brief   : Self-checking bench for alu_op_sequencer with a behavioural ALU.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic        clock;
   logic        clear;
   logic        start;
   logic [4:0]  opcode;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [31:0] alu_y;
   logic [31:0] alu_b;
   logic [4:0]  alu_control;
   logic        alu_in;
   logic [63:0] alu_z;
   logic [31:0] z_hi;
   logic [31:0] z_lo;

   int checks = 0;
   int errors = 0;

   alu_op_sequencer dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .opcode      (opcode),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal),
      .alu_y       (alu_y),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_in      (alu_in),
      .alu_z       (alu_z),
      .z_hi        (z_hi),
      .z_lo        (z_lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural datapath ALU; divide-by-zero yields a recognisable pattern.
   always_comb begin
      logic signed [63:0] prod;
      prod  = $signed(alu_y) * $signed(alu_b);
      alu_z = 64'd0;
      case (alu_control)
         5'b00011: alu_z = {32'd0, alu_y + alu_b};
         5'b00100: alu_z = {32'd0, alu_y - alu_b};
         5'b00101: alu_z = {32'd0, alu_y & alu_b};
         5'b00110: alu_z = {32'd0, alu_y | alu_b};
         5'b01001: alu_z = {32'd0, alu_y << alu_b[4:0]};
         5'b01111: alu_z = prod;
         5'b10000: alu_z = (alu_b == 32'd0) ? 64'hDEAD_BEEF_0BAD_F00D :
                           {$signed(alu_y) % $signed(alu_b), $signed(alu_y) / $signed(alu_b)};
         5'b10001: alu_z = {32'd0, -alu_y};
         5'b10010: alu_z = {32'd0, ~alu_y};
         default:  alu_z = 64'd0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic        ill;
      logic [31:0] hi;
      logic [31:0] lo;
      int          tog;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   // Issue one request and follow it to completion, checking timing and results.
   task automatic run_vec(input int idx, input vec_t v);
      int   n;
      int   toggles;
      logic seen;
      logic prev_in;
      @(negedge clock);
      start     = 1'b1;
      opcode    = v.op;
      operand_a = v.a;
      operand_b = v.b;
      prev_in   = alu_in;
      toggles   = 0;
      seen      = 1'b0;
      n         = 0;
      while (!seen && n < 20) begin
         @(negedge clock);
         start = 1'b0;
         n++;
         if (alu_in !== prev_in) toggles++;
         prev_in = alu_in;
         if (n == 1) chk($sformatf("v%0d busy_after_accept", idx), busy, 1'b1);
         if (done === 1'b1) seen = 1'b1;
      end
      chk($sformatf("v%0d done_seen", idx), seen, 1'b1);
      chk($sformatf("v%0d latency", idx), n, v.lat);
      chk($sformatf("v%0d illegal", idx), illegal, v.ill);
      chk($sformatf("v%0d busy_in_done", idx), busy, 1'b1);
      chk($sformatf("v%0d z_hi", idx), z_hi, v.hi);
      chk($sformatf("v%0d z_lo", idx), z_lo, v.lo);
      chk($sformatf("v%0d toggles", idx), toggles, v.tog);
      chk($sformatf("v%0d alu_y_hold", idx), alu_y, v.a);
      chk($sformatf("v%0d alu_ctrl_hold", idx), alu_control, v.op);
      @(negedge clock);
      chk($sformatf("v%0d done_pulse", idx), done, 1'b0);
      chk($sformatf("v%0d busy_idle", idx), busy, 1'b0);
   endtask

   initial begin
      int n;
      int dones;
      logic seen;

      tbl[0]  = '{5'b00011, 32'd5,        32'd3,  5, 1'b0, 32'h0,        32'h8,        1};
      tbl[1]  = '{5'b00100, 32'd10,       32'd3,  5, 1'b0, 32'h0,        32'h7,        1};
      tbl[2]  = '{5'b00101, 32'hF0F0,     32'hFF00, 5, 1'b0, 32'h0,      32'hF000,     1};
      tbl[3]  = '{5'b00110, 32'hF0F0,     32'hFF00, 5, 1'b0, 32'h0,      32'hFFF0,     1};
      tbl[4]  = '{5'b01111, 32'hFFFF_FFFF, 32'd2, 6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1};
      tbl[5]  = '{5'b10000, 32'd100,      32'd7,  8, 1'b0, 32'd2,        32'd14,       1};
      tbl[6]  = '{5'b00011, 32'd5,        32'd3,  5, 1'b0, 32'h0,        32'h8,        1};
      tbl[7]  = '{5'b01100, 32'd1,        32'd1,  2, 1'b1, 32'h0,        32'h8,        0};
      tbl[8]  = '{5'b11111, 32'd1,        32'd1,  2, 1'b1, 32'h0,        32'h8,        0};
      tbl[9]  = '{5'b10010, 32'd0,        32'd0,  5, 1'b0, 32'h0,        32'hFFFF_FFFF, 1};
      tbl[10] = '{5'b10001, 32'd5,        32'd0,  5, 1'b0, 32'h0,        32'hFFFF_FFFB, 1};
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
      tbl[11] = '{5'b10000, 32'd9,        32'd0,  2, 1'b1, 32'h0,        32'hFFFF_FFFB, 0};
`else
      tbl[11] = '{5'b10000, 32'd9,        32'd0,  8, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1};
`endif

      clear     = 1'b0;
      start     = 1'b0;
      opcode    = 5'd0;
      operand_a = 32'd0;
      operand_b = 32'd0;
      repeat (2) @(negedge clock);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset alu_in", alu_in, 1'b0);
      chk("reset z", {z_hi, z_lo}, 64'd0);
      chk("reset alu_y_b_ctrl", {alu_y, alu_b, alu_control}, 69'd0);
      clear = 1'b1;
      @(negedge clock);
      chk("idle illegal", illegal, 1'b0);

      for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

      // Extra starts while busy must be ignored: exactly one completion.
      @(negedge clock);
      start = 1'b1; opcode = 5'b10000; operand_a = 32'd100; operand_b = 32'd7;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1; opcode = 5'b00011; operand_a = 32'd1; operand_b = 32'd1;
      @(negedge clock);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      chk("busy_start dones", dones, 1);
      chk("busy_start z", {z_hi, z_lo}, {32'd2, 32'd14});
      chk("busy_start alu_y", alu_y, 32'd100);

      // A start coinciding with done is dropped.
      @(negedge clock);
      start = 1'b1; opcode = 5'b00011; operand_a = 32'd5; operand_b = 32'd3;
      @(negedge clock);
      start = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         @(negedge clock);
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      chk("done_start seen", seen, 1'b1);
      start = 1'b1; opcode = 5'b00100; operand_a = 32'd50; operand_b = 32'd1;
      @(negedge clock);
      start = 1'b0;
      chk("done_start busy", busy, 1'b0);
      chk("done_start alu_y", alu_y, 32'd5);

      // Reset in the middle of a divide discards everything.
      @(negedge clock);
      start = 1'b1; opcode = 5'b10000; operand_a = 32'd100; operand_b = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("midreset busy_before", busy, 1'b1);
      clear = 1'b0;
      #1;
      chk("midreset busy", busy, 1'b0);
      chk("midreset z", {z_hi, z_lo}, 64'd0);
      chk("midreset alu_in", alu_in, 1'b0);
      chk("midreset alu_y", alu_y, 32'd0);
      @(negedge clock);
      clear = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      chk("midreset no_done", dones, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts one operation request, then drives the Y operand, bus operand, opcode and evaluation trigger into the datapath ALU.
- Waits an opcode-dependent latency, then captures the 64-bit Z result into ZHI/ZLO registers and signals completion.
- Sits between the control unit and the ALU, replacing hand-sequenced Yin/ALU/Zin control steps.

Parameters:
- BASE_LAT, 1, wait cycles after trigger for add/sub/logic/shift/rotate/neg/not (min 1).
- MUL_LAT, 2, wait cycles after trigger for mul (01111) (min 1).
- DIV_LAT, 4, wait cycles after trigger for div (10000) (min 1).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- opcode  in  5  ALU operation code.
- operand_a  in  32  first operand (to Y).
- operand_b  in  32  second operand (bus side).
- busy  out  1  high from accept until DONE exits.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  valid with done; opcode unsupported.
- alu_y  out  32  Y operand to ALU.
- alu_b  out  32  bus operand to ALU.
- alu_control  out  5  opcode to ALU.
- alu_in  out  1  ALU evaluation trigger (toggle).
- alu_z  in  64  ALU result.
- z_hi  out  32  captured result [63:32] (div: remainder).
- z_lo  out  32  captured result [31:0] (div: quotient).

Behaviour:
- Reset (clear=0, async): state=IDLE; busy=0, done=0, illegal=0; alu_y, alu_b, alu_control, alu_in, z_hi, z_lo all 0; wait counter=0.
- Legal opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg, 10010 not. All others are illegal.
- States: IDLE, LOAD, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: when start=1, register operand_a into alu_y, operand_b into alu_b and opcode into alu_control. Go to LOAD; busy=1 from the next cycle.
- LOAD (1 cycle): operands are stable at the ALU.
  - Illegal opcode: go to DONE with illegal=1; no trigger is issued; z_hi/z_lo are unchanged.
  - Legal opcode: go to ISSUE.
- ISSUE (1 cycle): invert alu_in exactly once. The ALU evaluates on any alu_in change, so the trigger is a toggle, not a pulse. Load the wait counter with MUL_LAT, DIV_LAT or BASE_LAT by opcode. Go to WAIT.
- WAIT: decrement the counter each cycle; go to CAPTURE when it reaches 1.
- CAPTURE (1 cycle): z_hi <= alu_z[63:32], z_lo <= alu_z[31:0], stored verbatim. Results of 32-bit ops already carry the ALU's upper bits. Go to DONE.
- DONE (1 cycle): done=1; illegal valid; busy=1 in this cycle. Next state IDLE, with busy=0 and done=0.
- Latency, legal op: start sampled at edge 0 → done high after edge 4+LAT. Default add: done is asserted 5 cycles after start.
- Latency, illegal op: done high after edge 2.
- start while busy: ignored. There is no queue; the requester must wait for done.
- start in the same cycle done is high: ignored; the next request is accepted in IDLE.
- alu_y, alu_b and alu_control hold their values from LOAD until the next accept. This keeps the combinational ALU inputs stable through capture.
- z_hi and z_lo hold until the next CAPTURE. They survive illegal ops and are cleared only by reset.
- clear asserted mid-operation: immediate return to IDLE with all outputs zeroed; the in-flight result is discarded.
- alu_in is 0 after reset. The first ISSUE drives it to 1.

Optional Feature:
- Macro: ALU_SEQ_DIV_ZERO_TRAP_EN.
- Defined: in LOAD, opcode 10000 with alu_b==0 takes the illegal path: no trigger, illegal=1 at done, z_hi/z_lo unchanged.
- Undefined: divide-by-zero is issued normally, and whatever alu_z holds at CAPTURE is stored.

Decomposition:
- Shared package alu_pkg holds:
  - the 5-bit opcode localparams (OP_ADD ... OP_NOT);
  - the state enum typedef;
  - an is_legal_op function;
  - the latency-select function.
- One natural sub-module, alu_wait_counter: loadable down-counter with a terminal flag, used by WAIT.

Test Plan:
- Reset mid-WAIT: start div 100/7, assert clear after 2 cycles → busy=0, z_hi=z_lo=0, alu_in=0, no done.
- Add: start opcode 00011, a=0x0000_0005, b=0x0000_0003 → alu_in toggles once; done 5 cycles after start; z_lo=0x8, z_hi=0; illegal=0.
- Mul: a=0xFFFF_FFFF (−1), b=0x0000_0002 → done after 4+MUL_LAT cycles; {z_hi,z_lo}=0xFFFF_FFFF_FFFF_FFFE.
- Div: a=100, b=7 → z_lo=14, z_hi=2, done after 4+DIV_LAT cycles; a second start during busy is ignored (exactly one done).
- Illegal: opcode 01100 after a prior add with result 8 → done 2 cycles after start, illegal=1, alu_in not toggled, z_lo stays 8.
- Div by zero: a=9, b=0 with the macro defined → illegal=1, no toggle, z unchanged; without the macro → normal issue, illegal=0.
